// File: rtl/pll_drp_pkg.sv
// -----------------------------------------------------------------------------
// pll_drp_pkg
// Shared definitions for the PLL DRP reconfiguration controller: FSM state
// encoding, DRP register addresses, read-modify-write keep masks, legal
// multiplier/divider ranges and small helper functions.
// -----------------------------------------------------------------------------
package pll_drp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_ASSERT_RST = 3'd1,
      ST_RD         = 3'd2,
      ST_RD_WAIT    = 3'd3,
      ST_WR         = 3'd4,
      ST_WR_WAIT    = 3'd5,
      ST_WAIT_LOCK  = 3'd6,
      ST_ERR        = 3'd7
   } pll_state_e;

   // DRP register map, visited in this order
   localparam logic [6:0] ADDR_FB_REG1   = 7'h14;
   localparam logic [6:0] ADDR_FB_REG2   = 7'h15;
   localparam logic [6:0] ADDR_OUT0_REG1 = 7'h08;
   localparam logic [6:0] ADDR_OUT0_REG2 = 7'h09;

   // Bits preserved from the read-back value
   localparam logic [15:0] KEEP_REG1 = 16'h1000;
   localparam logic [15:0] KEEP_REG2 = 16'hFC00;

   localparam logic [6:0] MULT_MIN = 7'd2;
   localparam logic [6:0] MULT_MAX = 7'd64;
   localparam logic [6:0] DIV_MIN  = 7'd1;
   localparam logic [6:0] DIV_MAX  = 7'd64;

   function automatic logic [6:0] drp_addr(input logic [1:0] idx);
      case (idx)
         2'd0:    return ADDR_FB_REG1;
         2'd1:    return ADDR_FB_REG2;
         2'd2:    return ADDR_OUT0_REG1;
         2'd3:    return ADDR_OUT0_REG2;
         default: return ADDR_FB_REG1;
      endcase
   endfunction

   function automatic logic cfg_legal(input logic [6:0] mult, input logic [6:0] div);
      return (mult >= MULT_MIN) && (mult <= MULT_MAX) &&
             (div  >= DIV_MIN)  && (div  <= DIV_MAX);
   endfunction

endpackage

// File: rtl/pll_div_enc.sv
// -----------------------------------------------------------------------------
// pll_div_enc
// Combinational encoder turning a divide value N into the PLL counter fields.
// Ports:
//   div_val  in  7  divide value N
//   high     out 6  high-time count (N >> 1)
//   low      out 6  low-time count (N - high)
//   edge_bit out 1  odd-divide half-cycle adjust (N[0])
//   no_count out 1  bypass counter (N == 1)
// -----------------------------------------------------------------------------
module pll_div_enc (
   input  logic [6:0] div_val,
   output logic [5:0] high,
   output logic [5:0] low,
   output logic       edge_bit,
   output logic       no_count
);

   // Low time takes the extra cycle for odd N; out-of-range N is never used
   always_comb begin
      high     = div_val[6:1];
      low      = 6'(div_val - {1'b0, div_val[6:1]});
      edge_bit = div_val[0];
      no_count = (div_val == 7'd1);
   end

endmodule

// File: rtl/pll_drp_ctrl.sv
// -----------------------------------------------------------------------------
// pll_drp_ctrl
// Reprograms the PLL feedback multiplier and CLKOUT0 divider over DRP using
// read-modify-write of four registers while holding the PLL in reset, then
// waits for lock. All outputs are registered.
// Ports:
//   clk_sys, rst_sys            clock, async active-high reset
//   cfg_valid_i/cfg_ready_o     request handshake
//   cfg_mult_i, cfg_div_i       requested multiplier (2..64) / divider (1..64)
//   done_o                      one-cycle success pulse
//   err_o                       sticky error, cleared by next accepted request
//   drp_*                       DRP master port
//   pll_rst_o, pll_locked_i     PLL reset / asynchronous lock indication
//   rst_hold_o                  hold system reset while reconfiguring
// -----------------------------------------------------------------------------
module pll_drp_ctrl
   import pll_drp_pkg::*;
#(
   parameter int unsigned LockTimeout = 65535,
   parameter int unsigned DrdyTimeout = 255
) (
   input  logic        clk_sys,
   input  logic        rst_sys,
   input  logic        cfg_valid_i,
   output logic        cfg_ready_o,
   input  logic [6:0]  cfg_mult_i,
   input  logic [6:0]  cfg_div_i,
   output logic        done_o,
   output logic        err_o,
   output logic [6:0]  drp_daddr_o,
   output logic        drp_den_o,
   output logic        drp_dwe_o,
   output logic [15:0] drp_di_o,
   input  logic [15:0] drp_do_i,
   input  logic        drp_drdy_i,
   output logic        pll_rst_o,
   input  logic        pll_locked_i,
   output logic        rst_hold_o
);

   localparam int unsigned CNT_MAX = (LockTimeout > DrdyTimeout) ? LockTimeout : DrdyTimeout;
   localparam int          CNT_W   = $clog2(CNT_MAX + 32'd1);
   localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DrdyTimeout - 32'd1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LockTimeout - 32'd1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(32'd0);

   pll_state_e        state_r, state_nxt_s;
   logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
   logic [1:0]        idx_r, idx_nxt_s;
   logic [6:0]        mult_r, mult_nxt_s;
   logic [6:0]        div_r, div_nxt_s;
   logic              lock_meta_r, lock_sync_r;

   logic              ready_r, ready_nxt_s;
   logic              done_r, done_nxt_s;
   logic              err_r, err_nxt_s;
   logic              den_r, den_nxt_s;
   logic              dwe_r, dwe_nxt_s;
   logic [6:0]        daddr_r, daddr_nxt_s;
   logic [15:0]       di_r, di_nxt_s;
   logic              pll_rst_r, pll_rst_nxt_s;
   logic              rst_hold_r, rst_hold_nxt_s;

   logic [5:0]        mult_high_s, mult_low_s, div_high_s, div_low_s;
   logic              mult_edge_s, mult_nc_s, div_edge_s, div_nc_s;
   logic [5:0]        sel_high_s, sel_low_s;
   logic              sel_edge_s, sel_nc_s;
   logic [15:0]       wr_data_s;

   pll_div_enc u_mult_enc (
      .div_val  (mult_r),
      .high     (mult_high_s),
      .low      (mult_low_s),
      .edge_bit (mult_edge_s),
      .no_count (mult_nc_s)
   );

   pll_div_enc u_div_enc (
      .div_val  (div_r),
      .high     (div_high_s),
      .low      (div_low_s),
      .edge_bit (div_edge_s),
      .no_count (div_nc_s)
   );

   // Write word for the current index, merged with the read data arriving now
   always_comb begin
      if (idx_r[1] == 1'b0) begin
         sel_high_s = mult_high_s;
         sel_low_s  = mult_low_s;
         sel_edge_s = mult_edge_s;
         sel_nc_s   = mult_nc_s;
      end else begin
         sel_high_s = div_high_s;
         sel_low_s  = div_low_s;
         sel_edge_s = div_edge_s;
         sel_nc_s   = div_nc_s;
      end
      if (idx_r[0] == 1'b0) begin
         wr_data_s = (drp_do_i & KEEP_REG1) | {4'h0, sel_high_s, sel_low_s};
      end else begin
         wr_data_s = (drp_do_i & KEEP_REG2) | {8'h00, sel_edge_s, sel_nc_s, 6'h00};
      end
   end

   // Next-state and next-output logic; outputs change on state transitions
   always_comb begin
      state_nxt_s    = state_r;
      cnt_nxt_s      = cnt_r;
      idx_nxt_s      = idx_r;
      mult_nxt_s     = mult_r;
      div_nxt_s      = div_r;
      done_nxt_s     = 1'b0;
      err_nxt_s      = err_r;
      den_nxt_s      = 1'b0;
      dwe_nxt_s      = 1'b0;
      daddr_nxt_s    = daddr_r;
      di_nxt_s       = di_r;
      pll_rst_nxt_s  = pll_rst_r;
      rst_hold_nxt_s = rst_hold_r;
      case (state_r)
         ST_IDLE: begin
            if (cfg_valid_i && ready_r) begin
               mult_nxt_s = cfg_mult_i;
               div_nxt_s  = cfg_div_i;
               if (cfg_legal(cfg_mult_i, cfg_div_i)) begin
                  err_nxt_s      = 1'b0;
                  state_nxt_s    = ST_ASSERT_RST;
                  pll_rst_nxt_s  = 1'b1;
                  rst_hold_nxt_s = 1'b1;
               end else begin
                  err_nxt_s = 1'b1;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ASSERT_RST: begin
            state_nxt_s = ST_RD;
            idx_nxt_s   = 2'd0;
            den_nxt_s   = 1'b1;
            daddr_nxt_s = drp_addr(2'd0);
         end
         ST_RD: begin
            state_nxt_s = ST_RD_WAIT;
            cnt_nxt_s   = CNT_ZERO;
         end
         ST_RD_WAIT: begin
            if (drp_drdy_i) begin
               state_nxt_s = ST_WR;
               den_nxt_s   = 1'b1;
               dwe_nxt_s   = 1'b1;
               di_nxt_s    = wr_data_s;
            end else if (cnt_r == DRDY_LAST) begin
               state_nxt_s    = ST_ERR;
               err_nxt_s      = 1'b1;
               pll_rst_nxt_s  = 1'b0;
               rst_hold_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         ST_WR: begin
            state_nxt_s = ST_WR_WAIT;
            cnt_nxt_s   = CNT_ZERO;
         end
         ST_WR_WAIT: begin
            if (drp_drdy_i) begin
               cnt_nxt_s = CNT_ZERO;
               if (idx_r == 2'd3) begin
                  state_nxt_s   = ST_WAIT_LOCK;
                  pll_rst_nxt_s = 1'b0;
               end else begin
                  state_nxt_s = ST_RD;
                  idx_nxt_s   = idx_r + 2'd1;
                  den_nxt_s   = 1'b1;
                  daddr_nxt_s = drp_addr(idx_r + 2'd1);
               end
            end else if (cnt_r == DRDY_LAST) begin
               state_nxt_s    = ST_ERR;
               err_nxt_s      = 1'b1;
               pll_rst_nxt_s  = 1'b0;
               rst_hold_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         ST_WAIT_LOCK: begin
            if (lock_sync_r) begin
               state_nxt_s    = ST_IDLE;
               done_nxt_s     = 1'b1;
               rst_hold_nxt_s = 1'b0;
            end else if (cnt_r == LOCK_LAST) begin
               state_nxt_s    = ST_ERR;
               err_nxt_s      = 1'b1;
               pll_rst_nxt_s  = 1'b0;
               rst_hold_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         ST_ERR: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
      ready_nxt_s = (state_nxt_s == ST_IDLE);
   end

   // Two-flop synchroniser for the asynchronous PLL lock
   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) begin
         lock_meta_r <= 1'b0;
         lock_sync_r <= 1'b0;
      end else begin
         lock_meta_r <= pll_locked_i;
         lock_sync_r <= lock_meta_r;
      end
   end

   // State, counters, captured request and registered outputs
   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) begin
         state_r    <= ST_IDLE;
         cnt_r      <= CNT_ZERO;
         idx_r      <= 2'd0;
         mult_r     <= 7'd0;
         div_r      <= 7'd0;
         ready_r    <= 1'b1;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         den_r      <= 1'b0;
         dwe_r      <= 1'b0;
         daddr_r    <= 7'd0;
         di_r       <= 16'h0000;
         pll_rst_r  <= 1'b0;
         rst_hold_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         cnt_r      <= cnt_nxt_s;
         idx_r      <= idx_nxt_s;
         mult_r     <= mult_nxt_s;
         div_r      <= div_nxt_s;
         ready_r    <= ready_nxt_s;
         done_r     <= done_nxt_s;
         err_r      <= err_nxt_s;
         den_r      <= den_nxt_s;
         dwe_r      <= dwe_nxt_s;
         daddr_r    <= daddr_nxt_s;
         di_r       <= di_nxt_s;
         pll_rst_r  <= pll_rst_nxt_s;
         rst_hold_r <= rst_hold_nxt_s;
      end
   end

   assign cfg_ready_o = ready_r;
   assign done_o      = done_r;
   assign err_o       = err_r;
   assign drp_den_o   = den_r;
   assign drp_dwe_o   = dwe_r;
   assign drp_daddr_o = daddr_r;
   assign drp_di_o    = di_r;
   assign pll_rst_o   = pll_rst_r;
   assign rst_hold_o  = rst_hold_r;

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_drp_ctrl
// Self-checking bench for pll_drp_ctrl: a behavioural DRP slave and PLL lock
// model, a reference encoding of the expected register writes, and a linear
// directed/randomised sequence of requests.
// -----------------------------------------------------------------------------
module tb_pll_drp_ctrl;

   logic        clk = 1'b0;
   logic        rst_sys;
   logic        cfg_valid_i;
   logic        cfg_ready_o;
   logic [6:0]  cfg_mult_i;
   logic [6:0]  cfg_div_i;
   logic        done_o;
   logic        err_o;
   logic [6:0]  drp_daddr_o;
   logic        drp_den_o;
   logic        drp_dwe_o;
   logic [15:0] drp_di_o;
   logic [15:0] drp_do_i = 16'h0000;
   logic        drp_drdy_i = 1'b0;
   logic        pll_rst_o;
   logic        pll_locked_i = 1'b0;
   logic        rst_hold_o;

   // Stimulus-owned model controls
   logic [15:0] rd_mem [0:127];
   int          drdy_lat   = 2;
   bit          drdy_never = 1'b0;
   bit          lock_enable = 1'b1;
   int          lock_delay = 100;

   // Model-owned state and logs
   bit          m_busy = 1'b0;
   int          m_lat = 0;
   logic [6:0]  m_addr = 7'd0;
   bit          den_prev = 1'b0;
   int          den_count = 0;
   int          proto_err = 0;
   int          wr_n = 0;
   logic [6:0]  wr_addr_log [0:255];
   logic [15:0] wr_data_log [0:255];
   int          lock_cnt = 0;

   int n_assert = 0;
   int n_fail   = 0;

   pll_drp_ctrl #(.LockTimeout(1000), .DrdyTimeout(255)) dut (
      .clk_sys      (clk),
      .rst_sys      (rst_sys),
      .cfg_valid_i  (cfg_valid_i),
      .cfg_ready_o  (cfg_ready_o),
      .cfg_mult_i   (cfg_mult_i),
      .cfg_div_i    (cfg_div_i),
      .done_o       (done_o),
      .err_o        (err_o),
      .drp_daddr_o  (drp_daddr_o),
      .drp_den_o    (drp_den_o),
      .drp_dwe_o    (drp_dwe_o),
      .drp_di_o     (drp_di_o),
      .drp_do_i     (drp_do_i),
      .drp_drdy_i   (drp_drdy_i),
      .pll_rst_o    (pll_rst_o),
      .pll_locked_i (pll_locked_i),
      .rst_hold_o   (rst_hold_o)
   );

   always #5 clk = ~clk;

   // DRP slave: answers each access drdy_lat cycles later, logs writes, flags protocol misuse
   always @(negedge clk) begin
      drp_drdy_i = 1'b0;
      if (m_busy) begin
         m_lat = m_lat - 1;
         if (m_lat <= 0) begin
            drp_drdy_i = 1'b1;
            drp_do_i   = rd_mem[m_addr];
            m_busy     = 1'b0;
         end
      end
      if (drp_den_o) begin
         den_count = den_count + 1;
         if (den_prev || m_busy) proto_err = proto_err + 1;
         if (!pll_rst_o || !rst_hold_o) proto_err = proto_err + 1;
         if (drp_dwe_o) begin
            wr_addr_log[wr_n % 256] = drp_daddr_o;
            wr_data_log[wr_n % 256] = drp_di_o;
            wr_n = wr_n + 1;
         end
         if (!drdy_never) begin
            m_busy = 1'b1;
            m_lat  = drdy_lat;
            m_addr = drp_daddr_o;
         end
      end else if (drp_dwe_o) begin
         proto_err = proto_err + 1;
      end
      den_prev = drp_den_o;
   end

   // PLL lock model: unlocked while in reset, locks lock_delay cycles after release
   always @(negedge clk) begin
      if (pll_rst_o) begin
         pll_locked_i = 1'b0;
         lock_cnt     = 0;
      end else if (lock_enable) begin
         if (lock_cnt >= lock_delay) pll_locked_i = 1'b1;
         else lock_cnt = lock_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert = n_assert + 1;
      assert (obs === exp) else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: register word from divide value N and the read-back value
   function automatic logic [15:0] exp_word(input int n, input bit second, input logic [15:0] rd);
      int hi;
      int lo;
      hi = n / 2;
      lo = n - hi;
      if (!second) exp_word = (rd & 16'h1000) | 16'(hi * 64 + lo);
      else         exp_word = (rd & 16'hFC00) | 16'((n % 2) * 128 + ((n == 1) ? 64 : 0));
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, " ready"},    cfg_ready_o, 1);
      check({tag, " done"},     done_o, 0);
      check({tag, " err"},      err_o, 0);
      check({tag, " den"},      drp_den_o, 0);
      check({tag, " dwe"},      drp_dwe_o, 0);
      check({tag, " daddr"},    drp_daddr_o, 0);
      check({tag, " di"},       drp_di_o, 0);
      check({tag, " pll_rst"},  pll_rst_o, 0);
      check({tag, " rst_hold"}, rst_hold_o, 0);
   endtask

   // Full legal reconfiguration: checks writes against the reference and the completion
   task automatic run_config(input int m, input int d, input string tag, output int base);
      logic [6:0]  addrs [4];
      logic [15:0] exp_d [4];
      int ndone;
      int ncyc;
      bit fin;
      addrs[0] = 7'h14; addrs[1] = 7'h15; addrs[2] = 7'h08; addrs[3] = 7'h09;
      for (int i = 0; i < 4; i++) exp_d[i] = exp_word((i < 2) ? m : d, (i % 2) == 1, rd_mem[addrs[i]]);
      base = wr_n;
      cfg_mult_i  = 7'(m);
      cfg_div_i   = 7'(d);
      cfg_valid_i = 1'b1;
      @(negedge clk);
      cfg_valid_i = 1'b0;
      check({tag, " ready busy"}, cfg_ready_o, 0);
      check({tag, " err cleared"}, err_o, 0);
      ndone = 0; ncyc = 0; fin = 1'b0;
      while (!fin && ncyc < 3000) begin
         @(negedge clk);
         ncyc = ncyc + 1;
         if (done_o) begin
            ndone = ndone + 1;
            fin = 1'b1;
            check({tag, " hold at done"}, rst_hold_o, 0);
            check({tag, " pll_rst at done"}, pll_rst_o, 0);
         end else if (err_o) begin
            fin = 1'b1;
         end
      end
      check({tag, " completed"}, fin, 1);
      check({tag, " err"}, err_o, 0);
      @(negedge clk);
      check({tag, " done single"}, done_o, 0);
      check({tag, " ready idle"}, cfg_ready_o, 1);
      check({tag, " writes"}, wr_n - base, 4);
      for (int i = 0; i < 4; i++) begin
         check({tag, " waddr"}, wr_addr_log[(base + i) % 256], addrs[i]);
         check({tag, " wdata"}, wr_data_log[(base + i) % 256], exp_d[i]);
      end
      check({tag, " drp protocol"}, proto_err, 0);
   endtask

   initial begin
      int base;
      int m;
      int d;
      int den0;
      int nwr;
      bit found;
      logic [6:0] exp_addr [4];
      logic [6:0] bad_m [4];
      logic [6:0] bad_d [4];

      exp_addr[0] = 7'h14; exp_addr[1] = 7'h15; exp_addr[2] = 7'h08; exp_addr[3] = 7'h09;
      bad_m[0] = 7'd65; bad_m[1] = 7'd34; bad_m[2] = 7'd1;  bad_m[3] = 7'd127;
      bad_d[0] = 7'd17; bad_d[1] = 7'd0;  bad_d[2] = 7'd10; bad_d[3] = 7'd65;
      for (int i = 0; i < 128; i++) rd_mem[i] = 16'hFFFF;

      rst_sys = 1'b1; cfg_valid_i = 1'b0; cfg_mult_i = 7'd0; cfg_div_i = 7'd0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_sys = 1'b0;
      repeat (2) @(negedge clk);

      // Reference configuration with all-ones read-back
      run_config(34, 17, "m34d17", base);
      check("m34d17 0x14", wr_data_log[base % 256], 16'h1451);
      check("m34d17 0x15", wr_data_log[(base + 1) % 256], 16'hFC00);
      check("m34d17 0x08", wr_data_log[(base + 2) % 256], 16'h1209);
      check("m34d17 0x09", wr_data_log[(base + 3) % 256], 16'hFC80);

      // Divide by one: counter bypass
      run_config(8, 1, "div1", base);
      check("div1 0x08", wr_data_log[(base + 2) % 256], 16'h1001);
      check("div1 0x09", wr_data_log[(base + 3) % 256], 16'hFCC0);

      // Boundary and random legal settings with random read-back and latency
      run_config(64, 64, "max", base);
      run_config(2, 63, "min", base);
      for (int k = 0; k < 6; k++) begin
         m = $urandom_range(64, 2);
         d = $urandom_range(64, 1);
         drdy_lat = $urandom_range(5, 1);
         rd_mem[7'h14] = 16'($urandom());
         rd_mem[7'h15] = 16'($urandom());
         rd_mem[7'h08] = 16'($urandom());
         rd_mem[7'h09] = 16'($urandom());
         run_config(m, d, "rand", base);
      end
      drdy_lat = 2;
      for (int i = 0; i < 128; i++) rd_mem[i] = 16'hFFFF;

      // Out-of-range requests: error, no DRP access, ready again
      for (int k = 0; k < 4; k++) begin
         den0 = den_count;
         cfg_mult_i = bad_m[k]; cfg_div_i = bad_d[k]; cfg_valid_i = 1'b1;
         @(negedge clk);
         cfg_valid_i = 1'b0;
         check("illegal err", err_o, 1);
         check("illegal ready", cfg_ready_o, 1);
         repeat (3) @(negedge clk);
         check("illegal no den", den_count - den0, 0);
         check("illegal err sticky", err_o, 1);
      end

      // DRP never answers: error after the drdy timeout
      drdy_never = 1'b1;
      cfg_mult_i = 7'd20; cfg_div_i = 7'd5; cfg_valid_i = 1'b1;
      @(negedge clk);
      cfg_valid_i = 1'b0;
      check("drdy_to err cleared", err_o, 0);
      check("drdy_to hold", rst_hold_o, 1);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (drp_den_o) found = 1'b1;
      end
      check("drdy_to den seen", found, 1);
      repeat (255) @(negedge clk);
      check("drdy_to err early", err_o, 0);
      @(negedge clk);
      check("drdy_to err", err_o, 1);
      check("drdy_to pll_rst", pll_rst_o, 0);
      check("drdy_to hold", rst_hold_o, 1);
      @(negedge clk);
      check("drdy_to ready", cfg_ready_o, 1);
      check("drdy_to err kept", err_o, 1);
      drdy_never = 1'b0;

      // Lock never returns: error after the lock timeout, then a retry completes
      lock_enable = 1'b0;
      cfg_mult_i = 7'd20; cfg_div_i = 7'd4; cfg_valid_i = 1'b1;
      @(negedge clk);
      cfg_valid_i = 1'b0;
      check("lock_to pll_rst high", pll_rst_o, 1);
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         if (!pll_rst_o) found = 1'b1;
      end
      check("lock_to pll_rst fell", found, 1);
      repeat (999) @(negedge clk);
      check("lock_to err early", err_o, 0);
      @(negedge clk);
      check("lock_to err", err_o, 1);
      check("lock_to hold", rst_hold_o, 1);
      @(negedge clk);
      lock_enable = 1'b1;
      run_config(20, 4, "retry", base);

      // Reset during the third write wait, request held high throughout
      cfg_mult_i = 7'd30; cfg_div_i = 7'd7; cfg_valid_i = 1'b1;
      @(negedge clk);
      nwr = 0;
      for (int i = 0; i < 200 && nwr < 3; i++) begin
         check("hold no accept", cfg_ready_o, 0);
         if (drp_den_o && drp_dwe_o) begin
            check("hold write order", drp_daddr_o, exp_addr[nwr]);
            nwr = nwr + 1;
         end
         if (nwr < 3) @(negedge clk);
      end
      check("hold third write", nwr, 3);
      @(negedge clk);
      check("mid pll_rst before", pll_rst_o, 1);
      rst_sys = 1'b1;
      #1;
      check_reset_outputs("mid reset");
      cfg_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      rst_sys = 1'b0;
      repeat (4) @(negedge clk);
      check("post reset ready", cfg_ready_o, 1);
      check("post reset den", drp_den_o, 0);
      check("post reset done", done_o, 0);
      run_config($urandom_range(64, 2), $urandom_range(64, 1), "final", base);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
